mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS CPU. Sequences the shared datapath (one memory port, one ALU,
//  PC/IR/A/B/ALUOut registers) through fetch/decode/execute/memory/writeback per instruction. Consumes
//  IR opcode/funct and the ALU zero flag; drives every datapath enable/mux select. Waits on a memory
//  ready handshake. Sits beside the datapath inside the CPU top, one instance.
// PARAMETERS
//  ST_W      4   state register width (13 states used)
//  ALUC_W    4   ALU control code width
// PORTS
//  clk          in   1   rising-edge clock, single domain
//  rst          in   1   synchronous, active-low reset
//  opcode       in   6   IR[31:26]; valid from DECODE onward
//  funct        in   6   IR[5:0]; used only for R-type
//  zero         in   1   ALU zero flag, valid in BRANCH state
//  mem_ready    in   1   memory completes the current read/write this cycle
//  pc_en        out  1   PC load enable (already qualified for branches)
//  pc_src       out  2   0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target
//  iord         out  1   memory address: 0=PC, 1=ALUOut
//  mem_read     out  1   memory read strobe
//  mem_write    out  1   memory write strobe
//  ir_write     out  1   IR load enable
//  reg_dst      out  1   write reg: 0=rt, 1=rd
//  mem_to_reg   out  1   writeback data: 0=ALUOut, 1=MDR
//  reg_write    out  1   register-file write enable
//  alu_src_a    out  1   0=PC, 1=A
//  alu_src_b    out  2   0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  imm_zext     out  1   1 = zero-extend immediate (andi/ori)
//  alu_ctrl     out  4   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  illegal_op   out  1   one-cycle pulse on unsupported opcode/funct
//  state_out    out  4   current state, debug/testbench observation
// BEHAVIOUR
//  - rst=0 at a clk edge: state<=FETCH. While rst=0 every output above except state_out is forced 0.
//  - Moore outputs: combinational decode of state (plus zero/opcode/mem_ready where noted).
//  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000,
//    andi 001100, ori 001101, slti 001010. R funct: add 100000, sub 100010, and 100100, or 100101,
//    slt 101010, nor 100111.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ADD. Holds while mem_ready=0 (ir_write=pc_en=0).
//    Cycle with mem_ready=1: ir_write=1, pc_en=1, pc_src=0; next DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target to ALUOut). Next by opcode: lw/sw->MEM_ADDR,
//    R->EXEC_R, beq/bne->BRANCH, j->JUMP, I-arith->EXEC_I, else ILLEGAL.
//  - MEM_ADDR: A+imm (src_a=1, src_b=2, ADD); lw->MEM_READ, sw->MEM_WRITE.
//  - MEM_READ / MEM_WRITE: iord=1, strobe held until mem_ready=1; then MEM_WB / FETCH respectively.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - EXEC_R: src_a=1, src_b=0, alu_ctrl from funct; unknown funct -> ILLEGAL instead of R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - EXEC_I: src_a=1, src_b=2; addi ADD, slti SLT, andi AND+imm_zext, ori OR+imm_zext -> I_WB.
//  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; imm_zext and alu_ctrl held from EXEC_I -> FETCH.
//  - BRANCH: src_a=1, src_b=0, SUB, pc_src=1; pc_en = zero for beq, ~zero for bne -> FETCH.
//  - JUMP: pc_src=2, pc_en=1 -> FETCH.
//  - ILLEGAL: illegal_op=1 for exactly one cycle, no register/memory write -> FETCH (PC already +4).
//  - Latency (mem_ready tied 1): beq/bne/j 3, R/I-arith/sw 4, lw 5 cycles; each memory wait cycle adds 1.
//  - Reset mid-instruction: abandons it next edge; no partial reg_write/mem_write after rst returns high.
//  - Unused 13..15 state encodings -> FETCH next cycle.
// CONFIGURATION
//  MIPS_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] (+1 every clk with rst=1) and
//  instr_cnt[31:0] (+1 on each entry to FETCH from a completing state, ILLEGAL included); both
//  reset to 0, wrap at 2^32. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  - Package mips_ctrl_pkg: state enum (FETCH=0..ILLEGAL=12), opcode/funct localparams, alu_ctrl codes,
//    alu_src_b/pc_src encodings; shared with datapath and bench.
//  - Sub-module mips_alu_decoder: combinational funct -> {alu_ctrl, funct_valid}.
//  - Single always block for state register; separate combinational next-state and output decode.
// TESTING
//  - rst=0 two cycles, mem_ready=1 -> all outputs 0, state_out=0; after release FETCH asserts mem_read.
//  - add (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 in state 7 only.
//  - lw, mem_ready low 3 cycles in FETCH and 2 in MEM_READ -> 10 cycles total, ir_write/pc_en pulse once.
//  - beq zero=1 -> pc_en=1, pc_src=1 in BRANCH; bne zero=1 -> pc_en=0; j -> pc_en=1, pc_src=2.
//  - opcode 111111 and R funct 000001 -> illegal_op one-cycle pulse, no reg_write/mem_write, back to FETCH.
//  - rst=0 asserted in MEM_WRITE with mem_ready=0 -> state FETCH next edge, mem_write never seen with rst=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct values, ALU control codes and datapath mux encodings.
package mips_ctrl_pkg;

  localparam int ST_W   = 4;
  localparam int ALUC_W = 4;

  typedef enum logic [ST_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU control code; funct_valid flags supported functs.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_NOR:  alu_ctrl = ALU_NOR;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU. Defining MIPS_CTRL_PERF_EN
// adds cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              imm_zext,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              illegal_op,
`ifdef MIPS_CTRL_PERF_EN
  output logic [ST_W-1:0]   state_out,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`else
  output logic [ST_W-1:0]   state_out
`endif
);

  state_t            state;
  state_t            next_state;
  logic [ALUC_W-1:0] r_alu_ctrl;
  logic              funct_valid;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_ctrl    (r_alu_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  assign state_out = state;

  always_comb begin
    next_state = FETCH;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    imm_zext   = 1'b0;
    alu_ctrl   = ALU_ADD;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:                      next_state = MEM_ADDR;
          OP_RTYPE:                          next_state = EXEC_R;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_J:                              next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = EXEC_I;
          default:                           next_state = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        iord       = 1'b1;
        mem_read   = 1'b1;
        next_state = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WRITE: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready ? FETCH : MEM_WRITE;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = r_alu_ctrl;
        next_state = funct_valid ? R_WB : ILLEGAL;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_ctrl  = r_alu_ctrl;
      end
      // The immediate ALU setup stays stable through writeback.
      EXEC_I, I_WB: begin
        imm_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_ADD;
        endcase
        if (state == EXEC_I) begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          next_state = I_WB;
        end else begin
          reg_write = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
      end
      JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      ILLEGAL: illegal_op = 1'b1;
      default: next_state = FETCH;
    endcase

    // Held reset silences the datapath regardless of the current state.
    if (!rst) begin
      pc_en      = 1'b0;
      pc_src     = PCSRC_ALU;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      imm_zext   = 1'b0;
      alu_ctrl   = ALU_AND;
      illegal_op = 1'b0;
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  // An instruction retires when a real state other than FETCH hands back to FETCH.
  logic instr_done;
  assign instr_done = (state != FETCH) && (state <= ILLEGAL) && (next_state == FETCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl: reset, instruction
// sequencing, memory waits, branches, illegal decode and mid-instruction reset.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              zero;
  logic              mem_ready;
  logic              pc_en;
  logic [1:0]        pc_src;
  logic              iord;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              reg_write;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              imm_zext;
  logic [ALUC_W-1:0] alu_ctrl;
  logic              illegal_op;
  logic [ST_W-1:0]   state_out;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0]       cycle_cnt;
  logic [31:0]       instr_cnt;
`endif

  logic [18:0] all_outs;
  int          cmp_count;
  int          err_count;
  int          ir_pulses;
  int          pc_pulses;
  int          rw_pulses;
  logic [3:0]  lw_states [10];

  assign all_outs = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext,
                     alu_ctrl, illegal_op};

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .alu_ctrl   (alu_ctrl),
    .illegal_op (illegal_op),
`ifdef MIPS_CTRL_PERF_EN
    .state_out  (state_out),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`else
    .state_out  (state_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    ir_pulses = 0;
    pc_pulses = 0;
    rw_pulses = 0;
    rst       = 1'b0;
    applyStimulus(OP_RTYPE, FN_ADD, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_outs", 32'(all_outs), 32'd0);
    checkOutput("rst_state", 32'(state_out), 32'd0);

    rst = 1'b1;
    #1;
    checkOutput("fetch_mem_read", 32'(mem_read), 32'd1);

    // add: FETCH, DECODE, EXEC_R, R_WB, FETCH
    checkOutput("add_s0", 32'(state_out), 32'd0);
    checkOutput("add_ir_write", 32'(ir_write), 32'd1);
    checkOutput("add_pc_en", 32'(pc_en), 32'd1);
    checkOutput("add_f_rw", 32'(reg_write), 32'd0);
    tick();
    checkOutput("add_s1", 32'(state_out), 32'd1);
    checkOutput("add_d_srcb", 32'(alu_src_b), 32'd3);
    checkOutput("add_d_rw", 32'(reg_write), 32'd0);
    tick();
    checkOutput("add_s6", 32'(state_out), 32'd6);
    checkOutput("add_e_aluc", 32'(alu_ctrl), 32'b0010);
    checkOutput("add_e_srca", 32'(alu_src_a), 32'd1);
    checkOutput("add_e_rw", 32'(reg_write), 32'd0);
    tick();
    checkOutput("add_s7", 32'(state_out), 32'd7);
    checkOutput("add_wb_rw", 32'(reg_write), 32'd1);
    checkOutput("add_wb_rdst", 32'(reg_dst), 32'd1);
    tick();
    checkOutput("add_back_s0", 32'(state_out), 32'd0);
    checkOutput("add_back_rw", 32'(reg_write), 32'd0);

    // lw with 3 fetch wait cycles and 2 memory-read wait cycles
    lw_states = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    for (int c = 0; c < 10; c++) begin
      applyStimulus(OP_LW, 6'd0, 1'b0, (c < 3 || c == 6 || c == 7) ? 1'b0 : 1'b1);
      checkOutput("lw_state", 32'(state_out), 32'(lw_states[c]));
      if (c == 6) checkOutput("lw_iord", 32'(iord), 32'd1);
      if (c == 9) checkOutput("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
      ir_pulses += int'(ir_write);
      pc_pulses += int'(pc_en);
      rw_pulses += int'(reg_write);
      tick();
    end
    checkOutput("lw_ir_pulses", 32'(ir_pulses), 32'd1);
    checkOutput("lw_pc_pulses", 32'(pc_pulses), 32'd1);
    checkOutput("lw_rw_pulses", 32'(rw_pulses), 32'd1);
    checkOutput("lw_back_s0", 32'(state_out), 32'd0);

    // beq taken
    applyStimulus(OP_BEQ, 6'd0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("beq_state", 32'(state_out), 32'd10);
    checkOutput("beq_pc_en", 32'(pc_en), 32'd1);
    checkOutput("beq_pc_src", 32'(pc_src), 32'd1);
    checkOutput("beq_aluc", 32'(alu_ctrl), 32'b0110);
    tick();
    checkOutput("beq_back_s0", 32'(state_out), 32'd0);

    // bne with zero=1 is not taken
    applyStimulus(OP_BNE, 6'd0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("bne_state", 32'(state_out), 32'd10);
    checkOutput("bne_pc_en", 32'(pc_en), 32'd0);
    tick();

    // jump
    applyStimulus(OP_J, 6'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("j_state", 32'(state_out), 32'd11);
    checkOutput("j_pc_en", 32'(pc_en), 32'd1);
    checkOutput("j_pc_src", 32'(pc_src), 32'd2);
    tick();
    checkOutput("j_back_s0", 32'(state_out), 32'd0);

    // ori: zero-extended OR through EXEC_I and I_WB
    applyStimulus(OP_ORI, 6'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("ori_s8", 32'(state_out), 32'd8);
    checkOutput("ori_e_aluc", 32'(alu_ctrl), 32'b0001);
    checkOutput("ori_e_zext", 32'(imm_zext), 32'd1);
    checkOutput("ori_e_srcb", 32'(alu_src_b), 32'd2);
    tick();
    checkOutput("ori_s9", 32'(state_out), 32'd9);
    checkOutput("ori_wb_rw", 32'(reg_write), 32'd1);
    checkOutput("ori_wb_rdst", 32'(reg_dst), 32'd0);
    checkOutput("ori_wb_zext", 32'(imm_zext), 32'd1);
    checkOutput("ori_wb_aluc", 32'(alu_ctrl), 32'b0001);
    tick();

    // unsupported opcode
    applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("badop_state", 32'(state_out), 32'd12);
    checkOutput("badop_illegal", 32'(illegal_op), 32'd1);
    checkOutput("badop_rw", 32'(reg_write), 32'd0);
    checkOutput("badop_mw", 32'(mem_write), 32'd0);
    tick();
    checkOutput("badop_back_s0", 32'(state_out), 32'd0);
    checkOutput("badop_pulse_end", 32'(illegal_op), 32'd0);

    // unsupported R funct
    applyStimulus(OP_RTYPE, 6'b000001, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("badfn_s6", 32'(state_out), 32'd6);
    checkOutput("badfn_e_illegal", 32'(illegal_op), 32'd0);
    tick();
    checkOutput("badfn_s12", 32'(state_out), 32'd12);
    checkOutput("badfn_illegal", 32'(illegal_op), 32'd1);
    checkOutput("badfn_rw", 32'(reg_write), 32'd0);
    tick();
    checkOutput("badfn_back_s0", 32'(state_out), 32'd0);
    checkOutput("badfn_pulse_end", 32'(illegal_op), 32'd0);

    // sw interrupted by reset while waiting in MEM_WRITE
    applyStimulus(OP_SW, 6'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("sw_s2", 32'(state_out), 32'd2);
    applyStimulus(OP_SW, 6'd0, 1'b0, 1'b0);
    tick();
    checkOutput("sw_s5", 32'(state_out), 32'd5);
    checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
    checkOutput("sw_iord", 32'(iord), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("sw_rst_mw_forced", 32'(mem_write), 32'd0);
    tick();
    checkOutput("sw_rst_state", 32'(state_out), 32'd0);
    checkOutput("sw_rst_outs", 32'(all_outs), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("sw_rel_state", 32'(state_out), 32'd0);
    checkOutput("sw_rel_mw", 32'(mem_write), 32'd0);
    checkOutput("sw_rel_mem_read", 32'(mem_read), 32'd1);
    tick();
    checkOutput("sw_rel_hold", 32'(state_out), 32'd0);
    checkOutput("sw_rel_mw2", 32'(mem_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
